// File: rtl/i2c_reg_ctrl.sv
// Pointer-addressed 8-bit register bank behind an I2C slave byte interface, with a local write port.
// Optional build macro: I2C_REG_AUTOINC_EN enables pointer auto-increment on DATA-state accesses.
module i2c_reg_ctrl #(
  parameter int AW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_active,
  input  logic                  rd,
  input  logic [7:0]            rd_data,
  input  logic                  wr,
  output logic                  wr_en,
  output logic [7:0]            wr_data,
  input  logic                  rd_lock,
  input  logic                  loc_we,
  input  logic [AW-1:0]         loc_addr,
  input  logic [7:0]            loc_wdata,
  output logic [8*(2**AW)-1:0]  regs,
  output logic [AW-1:0]         ptr,
  output logic [1:0]            state,
  output logic                  conflict
);
  localparam int N = 2 ** AW;

`ifdef I2C_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PTR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_bank [N];
  logic [AW-1:0] r_ptr;
  logic          r_p_rd;
  logic          r_p_wr;
  // Remembers that bus_active was low last cycle, so IDLE only leaves on a fresh transaction.
  logic          r_bus_low;
  logic          r_wr_en;
  logic [7:0]    r_wr_data;
  logic          r_conflict;

  logic w_rd_rise;
  logic w_wr_rise;
  logic w_i2c_we;

  assign w_rd_rise = rd & ~r_p_rd;
  assign w_wr_rise = wr & ~r_p_wr;
  assign w_i2c_we  = bus_active && (r_state == S_DATA) && w_rd_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_p_rd     <= 1'b0;
      r_p_wr     <= 1'b0;
      r_bus_low  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= 8'h00;
      r_conflict <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_bank[i] <= 8'h00;
      end
    end else begin
      r_p_rd     <= rd;
      r_p_wr     <= wr;
      r_bus_low  <= ~bus_active;
      r_wr_en    <= ~rd_lock;
      r_wr_data  <= r_bank[r_ptr];
      r_conflict <= loc_we && w_i2c_we && (loc_addr == r_ptr);

      // The I2C write is issued last so it overrides a same-address local write.
      if (loc_we) r_bank[loc_addr] <= loc_wdata;
      if (w_i2c_we) r_bank[r_ptr] <= rd_data;

      if (!bus_active) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (r_bus_low) r_state <= S_PTR;
          S_PTR: begin
            if (w_rd_rise) begin
              r_ptr   <= rd_data[AW-1:0];
              r_state <= S_DATA;
            end else if (w_wr_rise) begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (AUTOINC && (w_rd_rise || w_wr_rise)) r_ptr <= r_ptr + 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_regs
      assign regs[8*gi +: 8] = r_bank[gi];
    end
  endgenerate

  assign ptr      = r_ptr;
  assign state    = r_state;
  assign wr_en    = r_wr_en;
  assign wr_data  = r_wr_data;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Scoreboard bench for i2c_reg_ctrl: a bench-side model pushes expected values, drained against DUT outputs.
module tb_i2c_reg_ctrl;
  localparam int AW = 3;
  localparam int N  = 8;

`ifdef I2C_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           bus_active;
  logic           rd;
  logic [7:0]     rd_data;
  logic           wr;
  logic           wr_en;
  logic [7:0]     wr_data;
  logic           rd_lock;
  logic           loc_we;
  logic [AW-1:0]  loc_addr;
  logic [7:0]     loc_wdata;
  logic [8*N-1:0] regs;
  logic [AW-1:0]  ptr;
  logic [1:0]     state;
  logic           conflict;

  i2c_reg_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .bus_active(bus_active), .rd(rd), .rd_data(rd_data),
    .wr(wr), .wr_en(wr_en), .wr_data(wr_data), .rd_lock(rd_lock),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .regs(regs), .ptr(ptr), .state(state), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef enum {K_REG, K_PTR, K_STATE, K_WRDATA, K_WREN, K_CONFLICT} kind_t;
  typedef struct {
    kind_t       kind;
    int          idx;
    logic [31:0] val;
    string       tag;
  } exp_t;
  exp_t sb[$];

  // Reference model of the bank
  logic [7:0]    m_regs [N];
  logic [AW-1:0] m_ptr;
  logic [1:0]    m_state;

  task automatic sb_push(input kind_t k, input int idx, input logic [31:0] v, input string tag);
    exp_t e;
    e.kind = k; e.idx = idx; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input kind_t k, input int idx);
    case (k)
      K_REG:      return {24'h0, regs[8*idx +: 8]};
      K_PTR:      return {29'h0, ptr};
      K_STATE:    return {30'h0, state};
      K_WRDATA:   return {24'h0, wr_data};
      K_WREN:     return {31'h0, wr_en};
      K_CONFLICT: return {31'h0, conflict};
      default:    return 32'hdead_beef;
    endcase
  endfunction

  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind, e.idx), e.val);
      $display("chk %-18s obs=0x%0h exp=0x%0h", e.tag, observe(e.kind, e.idx), e.val);
    end
  endtask

  task automatic expect_all(input string pfx);
    for (int i = 0; i < N; i++) sb_push(K_REG, i, {24'h0, m_regs[i]}, $sformatf("%s_reg%0d", pfx, i));
    sb_push(K_PTR, 0, {29'h0, m_ptr}, {pfx, "_ptr"});
    sb_push(K_STATE, 0, {30'h0, m_state}, {pfx, "_state"});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_txn();
    bus_active = 1'b0;
    repeat (2) tick();
    bus_active = 1'b1;
    repeat (3) tick();
    m_state = 2'd1;
  endtask

  task automatic stop_txn();
    bus_active = 1'b0;
    repeat (3) tick();
    m_state = 2'd0;
  endtask

  task automatic model_rd(input logic [7:0] b);
    if (m_state == 2'd1) begin
      m_ptr   = b[AW-1:0];
      m_state = 2'd2;
    end else if (m_state == 2'd2) begin
      m_regs[m_ptr] = b;
      if (AUTOINC) m_ptr = m_ptr + 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rd_data = b;
    rd = 1'b1;
    repeat (hold) tick();
    rd = 1'b0;
    repeat (4) tick();
    model_rd(b);
  endtask

  task automatic read_pulse();
    wr = 1'b1;
    repeat (4) tick();
    wr = 1'b0;
    repeat (4) tick();
    if (m_state == 2'd1) m_state = 2'd2;
    else if (m_state == 2'd2 && AUTOINC) m_ptr = m_ptr + 1'b1;
  endtask

  task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
    loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    tick();
    loc_we = 1'b0;
    m_regs[a] = d;
  endtask

  initial begin
    rst = 1'b1; bus_active = 1'b0; rd = 1'b0; rd_data = 8'h00; wr = 1'b0;
    rd_lock = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = 8'h00;
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    m_ptr = '0; m_state = 2'd0;
    repeat (3) tick();

    // Reset state
    expect_all("rst");
    sb_push(K_WRDATA, 0, 32'h00, "rst_wr_data");
    sb_push(K_WREN, 0, 32'h0, "rst_wr_en");
    sb_push(K_CONFLICT, 0, 32'h0, "rst_conflict");
    sb_drain();
    rst = 1'b0;
    repeat (2) tick();

    // Pointer byte then two data bytes
    start_txn();
    send_byte(8'h02, 4);
    send_byte(8'hAA, 4);
    send_byte(8'hBB, 4);
    stop_txn();
    expect_all("wr3");
    sb_drain();

    // Wrap from the top register
    start_txn();
    send_byte(8'h07, 4);
    send_byte(8'h11, 4);
    send_byte(8'h22, 4);
    stop_txn();
    expect_all("wrap");
    sb_drain();

    // Read sequence from a preloaded pointer
    loc_write(3'd4, 8'h5C);
    loc_write(3'd5, 8'h65);
    loc_write(3'd6, 8'h76);
    start_txn();
    send_byte(8'h04, 4);
    sb_push(K_WRDATA, 0, {24'h0, m_regs[m_ptr]}, "rdseq_0");
    sb_drain();
    read_pulse();
    sb_push(K_WRDATA, 0, {24'h0, m_regs[m_ptr]}, "rdseq_1");
    sb_drain();
    read_pulse();
    sb_push(K_WRDATA, 0, {24'h0, m_regs[m_ptr]}, "rdseq_2");
    expect_all("rdseq");
    sb_drain();
    stop_txn();

    // Read with no pointer byte keeps the current pointer
    start_txn();
    read_pulse();
    sb_push(K_PTR, 0, {29'h0, m_ptr}, "noptr_ptr");
    sb_push(K_STATE, 0, {30'h0, m_state}, "noptr_state");
    sb_push(K_WRDATA, 0, {24'h0, m_regs[m_ptr]}, "noptr_wr_data");
    sb_drain();
    stop_txn();

    // Same-address collision: I2C wins, conflict pulses once
    start_txn();
    send_byte(8'h01, 4);
    rd_data = 8'h44; rd = 1'b1;
    loc_we = 1'b1; loc_addr = 3'd1; loc_wdata = 8'h33;
    tick();
    loc_we = 1'b0;
    sb_push(K_CONFLICT, 0, 32'h1, "coll_conflict1");
    sb_drain();
    tick();
    sb_push(K_CONFLICT, 0, 32'h0, "coll_conflict0");
    sb_drain();
    repeat (2) tick();
    rd = 1'b0;
    repeat (4) tick();
    m_regs[1] = 8'h33;
    model_rd(8'h44);
    expect_all("coll");
    sb_drain();

    // Different-address concurrent writes both land
    rd_data = 8'h55; rd = 1'b1;
    loc_we = 1'b1; loc_addr = 3'd6; loc_wdata = 8'h66;
    tick();
    loc_we = 1'b0;
    sb_push(K_CONFLICT, 0, 32'h0, "diff_conflict");
    sb_drain();
    repeat (3) tick();
    rd = 1'b0;
    repeat (4) tick();
    m_regs[6] = 8'h66;
    model_rd(8'h55);
    expect_all("diff");
    sb_drain();

    // Long rd strobe acts once
    send_byte(8'hC3, 20);
    expect_all("hold");
    sb_drain();
    stop_txn();

    // rd_lock gates wr_en with one cycle latency
    rd_lock = 1'b1;
    tick();
    sb_push(K_WREN, 0, 32'h0, "lock_wr_en0");
    sb_drain();
    rd_lock = 1'b0;
    tick();
    sb_push(K_WREN, 0, 32'h1, "lock_wr_en1");
    sb_drain();

    // Reset mid-DATA, then no restart without a bus_active low phase
    start_txn();
    send_byte(8'h03, 4);
    send_byte(8'h9A, 4);
    rst = 1'b1;
    tick();
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    m_ptr = '0; m_state = 2'd0;
    expect_all("midrst");
    sb_push(K_WRDATA, 0, 32'h00, "midrst_wr_data");
    sb_push(K_WREN, 0, 32'h0, "midrst_wr_en");
    sb_push(K_CONFLICT, 0, 32'h0, "midrst_conflict");
    sb_drain();
    rst = 1'b0;
    repeat (4) tick();
    sb_push(K_STATE, 0, 32'h0, "postrst_state");
    sb_drain();
    stop_txn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
